fetch_ifid_stage: RTL and testbench
===================================

// Module: fetch_ifid_stage
// PURPOSE
// - Fetch stage plus IF/ID pipeline register. Feeds the ID stage, which feeds the ID/EX register.
// - Owns the PC and drives the instruction-memory address (combinational read, same cycle).
// - Detects load-use hazards against the instruction in EX and stalls. Flushes on taken branches and jumps from EX.
// PARAMETERS
// - PC_W    9   PC / instruction-address width (byte address)
// - INS_W   32  instruction width
// - RF_AW   5   register-file address width
// - CNT_W   16  width of the saturating stall and flush counters
// PORTS
// - clk            in   1      clock, rising edge
// - reset          in   1      asynchronous, active-high reset
// - imem_addr      out  PC_W   current PC, sent to instruction memory
// - imem_instr     in   INS_W  instruction at imem_addr, same cycle
// - PCSrc          in   1      branch/jump taken, resolved in EX
// - BrPC           in   PC_W   redirect target from EX
// - IDEX_IsLoad    in   1      instruction now in EX is a load
// - IDEX_RD        in   RF_AW  destination register of the instruction in EX
// - IFID_PC        out  PC_W   PC of the instruction held in IF/ID
// - IFID_PCPlus4   out  PC_W   IFID_PC + 4
// - IFID_Instr     out  INS_W  held instruction
// - IFID_Valid     out  1      held instruction is real (0 = bubble)
// - id_bubble      out  1      ID must drive all-zero control into ID/EX this cycle
// - stall_cnt      out  CNT_W  load-use stall cycles, saturating
// - flush_cnt      out  CNT_W  flush events, saturating
// BEHAVIOUR
// - Reset (async, immediate):
//   - PC = 0, IFID_PC = 0, IFID_PCPlus4 = 0
//   - IFID_Instr = NOP (32'h00000013), IFID_Valid = 0
//   - stall_cnt = 0, flush_cnt = 0
//   - While reset is high, id_bubble = 0.
// - First fetch: PC = 0 in the first cycle after reset release. Its instruction appears in IF/ID one edge later.
// - Hazard, combinational:
//   - hazard = IDEX_IsLoad & IFID_Valid & (IDEX_RD != 0) & ((uses_rs1 & rs1 == IDEX_RD) | (uses_rs2 & rs2 == IDEX_RD))
//   - rs1 = IFID_Instr[19:15], rs2 = IFID_Instr[24:20]
//   - uses_rs1 is 0 for LUI, AUIPC and JAL, and 1 for all other opcodes.
//   - uses_rs2 is 1 only for R-type (0110011), store (0100011) and branch (1100011).
// - Per-edge priority, highest first:
//   1. PCSrc = 1 (flush; overrides hazard):
//      - PC <= {BrPC[PC_W-1:2], 2'b00}
//      - IF/ID <= NOP with Valid = 0, IFID_PC and IFID_PCPlus4 = 0
//      - flush_cnt increments
//   2. hazard = 1 (stall):
//      - PC holds and all IF/ID fields hold.
//      - id_bubble = 1 in the same cycle.
//      - stall_cnt increments.
//   3. Otherwise (advance):
//      - IF/ID <= {PC, PC + 4, imem_instr} with Valid = 1
//      - PC <= PC + 4
// - Arithmetic: PC + 4 is computed modulo 2^PC_W, so it wraps (0x1FC + 4 -> 0x000 at PC_W = 9).
// - id_bubble = hazard & ~PCSrc. A flush in the same cycle squashes the stall.
// - One load-use stall lasts exactly 1 cycle. Next cycle the load has moved to MEM, so IDEX_IsLoad deasserts (ID/EX holds a bubble).
// - Counters saturate at all-ones and never wrap.
// - Reset asserted mid-stall or mid-flush: the reset values apply at once. No pending redirect survives reset.
// STRUCTURE
// - Shared package pipe_pkg:
//   - NOP_INSTR
//   - opcode localparams: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
//   - functions uses_rs1(opcode) and uses_rs2(opcode)
// - One sub-module, hazard_unit: purely combinational, produces hazard. Instantiated once.
// - PC, IF/ID and counter registers live in this module. No further hierarchy.
// TESTING
// - Reset then 3 advance cycles, imem returns 0x00100093 / 0x00200113 / 0x00308193:
//   - expect IFID_PC = 0x0, then 0x4, then 0x8; IFID_Valid = 1; imem_addr = 0xC.
// - Load-use: IDEX_IsLoad = 1, IDEX_RD = 5, IFID_Instr = add x6,x5,x7:
//   - id_bubble = 1 for 1 cycle; PC and IF/ID unchanged; stall_cnt = 1.
// - No false stall:
//   - IDEX_RD = 0 with rs1 = 0 -> no stall.
//   - lui x5 with IDEX_RD = 5 -> no stall.
//   - addi x6,x5,1 with IDEX_RD = 7 -> no stall.
// - Flush beats stall: hazard and PCSrc = 1, BrPC = 0x043 in the same cycle:
//   - PC <= 0x040; IFID_Valid = 0; IFID_Instr = NOP; id_bubble = 0; flush_cnt = 1.
// - Wrap: PC = 0x1FC, advance -> PC = 0x000 and IFID_PCPlus4 = 0x000.
// - Async reset asserted mid-stall, between edges:
//   - outputs reach reset values without waiting for a clock edge.
//   - after release, fetch restarts at PC = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: NOP encoding, base opcodes and register-use decode helpers.
package pipe_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   function automatic logic uses_rs1(input logic [6:0] opcode);
      return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
   endfunction

   function automatic logic uses_rs2(input logic [6:0] opcode);
      return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the instruction in IF/ID and a load sitting in EX.
module hazard_unit
   import pipe_pkg::*;
#(
   parameter int unsigned INS_W = 32,
   parameter int unsigned RF_AW = 5
) (
   input  logic [INS_W-1:0] instr_i,
   input  logic             valid_i,
   input  logic             ex_is_load_i,
   input  logic [RF_AW-1:0] ex_rd_i,
   output logic             hazard_o
);

   logic [6:0]       opcode;
   logic [RF_AW-1:0] rs1;
   logic [RF_AW-1:0] rs2;
   logic             rs1_hit;
   logic             rs2_hit;
   logic             unused_instr_bits;

   assign opcode  = instr_i[6:0];
   assign rs1     = instr_i[15 +: RF_AW];
   assign rs2     = instr_i[20 +: RF_AW];

   assign rs1_hit = uses_rs1(opcode) && (rs1 == ex_rd_i);
   assign rs2_hit = uses_rs2(opcode) && (rs2 == ex_rd_i);

   // x0 is never a real dependency.
   assign hazard_o = ex_is_load_i && valid_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

   assign unused_instr_bits = ^{instr_i[INS_W-1:25], instr_i[14:7]};

endmodule

// File: rtl/fetch_ifid_stage.sv
// Fetch stage: owns the PC, drives instruction memory and holds the IF/ID pipeline register.
module fetch_ifid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned PC_W  = 9,
   parameter int unsigned INS_W = 32,
   parameter int unsigned RF_AW = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   output logic [PC_W-1:0]  imem_addr,
   input  logic [INS_W-1:0] imem_instr,
   input  logic             PCSrc,
   input  logic [PC_W-1:0]  BrPC,
   input  logic             IDEX_IsLoad,
   input  logic [RF_AW-1:0] IDEX_RD,
   output logic [PC_W-1:0]  IFID_PC,
   output logic [PC_W-1:0]  IFID_PCPlus4,
   output logic [INS_W-1:0] IFID_Instr,
   output logic             IFID_Valid,
   output logic             id_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_plus4;
   logic [PC_W-1:0]  ifid_pc_q;
   logic [PC_W-1:0]  ifid_pc4_q;
   logic [INS_W-1:0] ifid_instr_q;
   logic             ifid_valid_q;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic             hazard;
   logic             stall;
   logic             unused_brpc_lsb;

   hazard_unit #(
      .INS_W (INS_W),
      .RF_AW (RF_AW)
   ) u_hazard_unit (
      .instr_i      (ifid_instr_q),
      .valid_i      (ifid_valid_q),
      .ex_is_load_i (IDEX_IsLoad),
      .ex_rd_i      (IDEX_RD),
      .hazard_o     (hazard)
   );

   // Wraps modulo 2^PC_W by construction.
   assign pc_plus4 = pc_q + PC_W'(4);

   // A redirect from EX squashes any stall in the same cycle.
   assign stall = hazard && !PCSrc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q         <= '0;
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_instr_q <= INS_W'(NOP_INSTR);
         ifid_valid_q <= 1'b0;
      end else if (PCSrc) begin
         pc_q         <= {BrPC[PC_W-1:2], 2'b00};
         ifid_pc_q    <= '0;
         ifid_pc4_q   <= '0;
         ifid_instr_q <= INS_W'(NOP_INSTR);
         ifid_valid_q <= 1'b0;
      end else if (!hazard) begin
         pc_q         <= pc_plus4;
         ifid_pc_q    <= pc_q;
         ifid_pc4_q   <= pc_plus4;
         ifid_instr_q <= imem_instr;
         ifid_valid_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (PCSrc && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign imem_addr    = pc_q;
   assign IFID_PC      = ifid_pc_q;
   assign IFID_PCPlus4 = ifid_pc4_q;
   assign IFID_Instr   = ifid_instr_q;
   assign IFID_Valid   = ifid_valid_q;
   assign id_bubble    = stall && !reset;
   assign stall_cnt    = stall_cnt_q;
   assign flush_cnt    = flush_cnt_q;

   assign unused_brpc_lsb = ^BrPC[1:0];

endmodule

// File: tb/tb_fetch_ifid_stage.sv
// Self-checking bench for fetch_ifid_stage: directed scenarios plus randomized run against a model.
module tb_fetch_ifid_stage;

   localparam int PC_W  = 9;
   localparam int INS_W = 32;
   localparam int RF_AW = 5;
   localparam int CNT_W = 16;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic             clk = 1'b0;
   logic             reset;
   logic [PC_W-1:0]  imem_addr;
   logic [INS_W-1:0] imem_instr;
   logic             PCSrc;
   logic [PC_W-1:0]  BrPC;
   logic             IDEX_IsLoad;
   logic [RF_AW-1:0] IDEX_RD;
   logic [PC_W-1:0]  IFID_PC;
   logic [PC_W-1:0]  IFID_PCPlus4;
   logic [INS_W-1:0] IFID_Instr;
   logic             IFID_Valid;
   logic             id_bubble;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   logic [31:0] mem [0:127];
   assign imem_instr = mem[imem_addr[8:2]];

   always #5 clk = ~clk;

   fetch_ifid_stage #(
      .PC_W  (PC_W),
      .INS_W (INS_W),
      .RF_AW (RF_AW),
      .CNT_W (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_addr    (imem_addr),
      .imem_instr   (imem_instr),
      .PCSrc        (PCSrc),
      .BrPC         (BrPC),
      .IDEX_IsLoad  (IDEX_IsLoad),
      .IDEX_RD      (IDEX_RD),
      .IFID_PC      (IFID_PC),
      .IFID_PCPlus4 (IFID_PCPlus4),
      .IFID_Instr   (IFID_Instr),
      .IFID_Valid   (IFID_Valid),
      .id_bubble    (id_bubble),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [8:0]  m_pc;
   logic [8:0]  m_ifid_pc;
   logic [8:0]  m_ifid_pc4;
   logic [31:0] m_instr;
   logic        m_valid;
   int          m_stall;
   int          m_flush;

   function automatic void model_reset();
      m_pc = 0; m_ifid_pc = 0; m_ifid_pc4 = 0; m_instr = NOP; m_valid = 0;
      m_stall = 0; m_flush = 0;
   endfunction

   function automatic bit ref_hazard();
      logic [6:0] op;
      bit u1, u2;
      op = m_instr[6:0];
      u1 = !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
      u2 = (op == 7'h33 || op == 7'h23 || op == 7'h63);
      return IDEX_IsLoad && m_valid && (IDEX_RD != 0) &&
             ((u1 && m_instr[19:15] == IDEX_RD) || (u2 && m_instr[24:20] == IDEX_RD));
   endfunction

   function automatic void model_edge();
      bit hz;
      hz = ref_hazard();
      if (PCSrc) begin
         m_pc = BrPC & 9'h1FC;
         m_ifid_pc = 0; m_ifid_pc4 = 0; m_instr = NOP; m_valid = 0;
         if (m_flush < 65535) m_flush++;
      end else if (hz) begin
         if (m_stall < 65535) m_stall++;
      end else begin
         m_ifid_pc  = m_pc;
         m_ifid_pc4 = 9'((int'(m_pc) + 4) % 512);
         m_instr    = mem[m_pc[8:2]];
         m_valid    = 1;
         m_pc       = m_ifid_pc4;
      end
   endfunction

   task automatic clock();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit ld, input logic [4:0] rd, input bit src, input logic [8:0] br);
      IDEX_IsLoad = ld; IDEX_RD = rd; PCSrc = src; BrPC = br;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(0, 0, 0, 0);
      #12;
      model_reset();
      n_vec++;
      if (imem_addr !== 9'h000) begin
         n_err++; $display("FAIL reset_pc: got %h want 000", imem_addr);
      end
      n_vec++;
      if ({IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid} !== {9'h0, 9'h0, NOP, 1'b0}) begin
         n_err++; $display("FAIL reset_ifid: got pc=%h pc4=%h ins=%h v=%b", IFID_PC, IFID_PCPlus4,
                           IFID_Instr, IFID_Valid);
      end
      n_vec++;
      if ({id_bubble, stall_cnt, flush_cnt} !== {1'b0, 16'h0, 16'h0}) begin
         n_err++; $display("FAIL reset_misc: got bub=%b stall=%0d flush=%0d want 0/0/0", id_bubble,
                           stall_cnt, flush_cnt);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_advance();
      for (int i = 0; i < 3; i++) begin
         clock();
         n_vec++;
         if ({IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid} !==
             {9'(i * 4), 9'(i * 4 + 4), mem[i], 1'b1}) begin
            n_err++; $display("FAIL advance_%0d: got pc=%h pc4=%h ins=%h v=%b", i, IFID_PC,
                              IFID_PCPlus4, IFID_Instr, IFID_Valid);
         end
      end
      n_vec++;
      if (imem_addr !== 9'h00C) begin
         n_err++; $display("FAIL advance_addr: got %h want 00c", imem_addr);
      end
   endtask

   task automatic test_load_use();
      clock();  // add x6,x5,x7 enters IF/ID
      drive(1, 5, 0, 0);
      #2;
      n_vec++;
      if (id_bubble !== 1'b1) begin
         n_err++; $display("FAIL load_use_bubble: got %b want 1", id_bubble);
      end
      clock();
      n_vec++;
      if ({imem_addr, IFID_PC, IFID_Instr, IFID_Valid, stall_cnt} !==
          {9'h010, 9'h00C, 32'h0072_8333, 1'b1, 16'd1}) begin
         n_err++; $display("FAIL load_use_hold: got addr=%h pc=%h ins=%h v=%b stall=%0d",
                           imem_addr, IFID_PC, IFID_Instr, IFID_Valid, stall_cnt);
      end
      drive(0, 0, 0, 0);
      #2;
      n_vec++;
      if (id_bubble !== 1'b0) begin
         n_err++; $display("FAIL load_use_one_cycle: got %b want 0", id_bubble);
      end
      clock();
   endtask

   task automatic test_no_false_stall();
      logic [4:0] rds [3];
      rds[0] = 0; rds[1] = 5; rds[2] = 7;
      for (int i = 0; i < 3; i++) begin
         drive(1, rds[i], 0, 0);
         #2;
         n_vec++;
         if (id_bubble !== 1'b0) begin
            n_err++; $display("FAIL no_false_stall_%0d: bubble got %b want 0", i, id_bubble);
         end
         clock();
         n_vec++;
         if ({IFID_PC, IFID_Valid, stall_cnt} !== {9'(8'h14 + 4 * i), 1'b1, 16'd1}) begin
            n_err++; $display("FAIL no_false_adv_%0d: got pc=%h v=%b stall=%0d", i, IFID_PC,
                              IFID_Valid, stall_cnt);
         end
      end
   endtask

   task automatic test_flush_beats_stall();
      drive(1, 5, 1, 9'h043);  // IF/ID holds add x6,x5,x7 from 0x1C
      #2;
      n_vec++;
      if (id_bubble !== 1'b0) begin
         n_err++; $display("FAIL flush_bubble: got %b want 0", id_bubble);
      end
      clock();
      n_vec++;
      if ({imem_addr, IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid, flush_cnt, stall_cnt} !==
          {9'h040, 9'h0, 9'h0, NOP, 1'b0, 16'd1, 16'd1}) begin
         n_err++; $display("FAIL flush_state: got addr=%h pc=%h ins=%h v=%b flush=%0d stall=%0d",
                           imem_addr, IFID_PC, IFID_Instr, IFID_Valid, flush_cnt, stall_cnt);
      end
      drive(0, 0, 0, 0);
   endtask

   task automatic test_wrap();
      drive(0, 0, 1, 9'h1FC);
      clock();
      drive(0, 0, 0, 0);
      clock();
      n_vec++;
      if ({imem_addr, IFID_PC, IFID_PCPlus4} !== {9'h000, 9'h1FC, 9'h000}) begin
         n_err++; $display("FAIL wrap: got addr=%h pc=%h pc4=%h want 000/1fc/000", imem_addr,
                           IFID_PC, IFID_PCPlus4);
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(0, 0, 1, 9'h01C);
      clock();
      drive(0, 0, 0, 0);
      clock();
      drive(1, 5, 0, 0);
      #2;
      n_vec++;
      if (id_bubble !== 1'b1) begin
         n_err++; $display("FAIL midstall_setup: bubble got %b want 1", id_bubble);
      end
      reset = 1'b1;
      #1;
      n_vec++;
      if ({imem_addr, IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid, id_bubble, stall_cnt,
           flush_cnt} !== {9'h0, 9'h0, 9'h0, NOP, 1'b0, 1'b0, 16'h0, 16'h0}) begin
         n_err++; $display("FAIL async_reset: got addr=%h pc=%h ins=%h v=%b bub=%b st=%0d fl=%0d",
                           imem_addr, IFID_PC, IFID_Instr, IFID_Valid, id_bubble, stall_cnt,
                           flush_cnt);
      end
      model_reset();
      drive(0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      clock();
      n_vec++;
      if ({imem_addr, IFID_PC, IFID_Instr, IFID_Valid} !== {9'h004, 9'h000, mem[0], 1'b1}) begin
         n_err++; $display("FAIL restart: got addr=%h pc=%h ins=%h v=%b", imem_addr, IFID_PC,
                           IFID_Instr, IFID_Valid);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [9];
      logic [31:0] w;
      ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
      ops[5] = 7'h6F; ops[6] = 7'h67; ops[7] = 7'h37; ops[8] = 7'h17;
      w = $urandom;
      w[6:0]   = ops[$urandom_range(0, 8)];
      w[19:15] = 5'($urandom_range(0, 3));
      w[24:20] = 5'($urandom_range(0, 3));
      return w;
   endfunction

   task automatic test_random();
      for (int i = 0; i < 128; i++) mem[i] = rand_instr();
      for (int c = 0; c < 400; c++) begin
         drive(($urandom % 2) == 0, 5'($urandom_range(0, 3)), ($urandom % 8) == 0, 9'($urandom));
         #2;
         n_vec++;
         if (id_bubble !== (ref_hazard() && !PCSrc)) begin
            n_err++; $display("FAIL rand_bubble c=%0d: got %b want %b", c, id_bubble,
                              ref_hazard() && !PCSrc);
         end
         clock();
         n_vec++;
         if ({imem_addr, IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid, stall_cnt, flush_cnt} !==
             {m_pc, m_ifid_pc, m_ifid_pc4, m_instr, m_valid, 16'(m_stall), 16'(m_flush)}) begin
            n_err++; $display("FAIL rand_state c=%0d: got %h/%h/%h/%h/%b/%0d/%0d want %h/%h/%h/%h/%b/%0d/%0d",
                              c, imem_addr, IFID_PC, IFID_PCPlus4, IFID_Instr, IFID_Valid,
                              stall_cnt, flush_cnt, m_pc, m_ifid_pc, m_ifid_pc4, m_instr, m_valid,
                              m_stall, m_flush);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = rand_instr();
      mem[0] = 32'h0010_0093;  // addi x1,x0,1
      mem[1] = 32'h0020_0113;
      mem[2] = 32'h0030_8193;
      mem[3] = 32'h0072_8333;  // add x6,x5,x7
      mem[4] = 32'h0010_0093;  // addi x1,x0,1 (rs1 = x0)
      mem[5] = 32'h1234_52B7;  // lui x5
      mem[6] = 32'h0012_8313;  // addi x6,x5,1
      mem[7] = 32'h0072_8333;  // add x6,x5,x7
      test_reset();
      test_advance();
      test_load_use();
      test_no_false_stall();
      test_flush_beats_stall();
      test_wrap();
      test_reset_mid_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
